// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the capture FSM state type.
package fb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int QVGA_W    = 320;
  localparam int QVGA_H    = 240;
  localparam int FB_DEPTH  = 76800;

  // SYNC waits for the first vertical blank so a partial frame is never
  // written. VBLANK arms the next frame. ACTIVE captures and SKIP discards.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    SKIP   = 2'd3
  } fb_state_t;

endpackage

// File: rtl/rgb565_byte_pair.sv
// Pairs the camera's high/low bytes into RGB565 pixels. The completion
// pulse is combinational, so the pixel is valid in the same cycle as the
// low byte on cam_data.
module rgb565_byte_pair (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       href,
  input  logic [7:0] cam_data,
  output logic       pix_done,
  output logic [7:0] hi_byte
);

  logic phase;

  // Toggle the byte phase on each valid byte. Fall back to the high-byte
  // phase whenever the line or the capture window closes, which also drops
  // a dangling high byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= 1'b0;
      hi_byte <= 8'h00;
    end else if (en && href) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      phase <= ~phase;
      if (!phase) hi_byte <= cam_data;
    end else begin
      phase <= 1'b0;
    end
  end

  assign pix_done = en & href & phase;

endmodule

// File: rtl/ov7670_fb_writer.sv
// Writes RGB565 pixels from an OV7670-style byte stream into a frame buffer.
// Frames are framed by vsync and lines by href. Capture is armed per frame
// by cap_en, and oversized lines or frames are clipped and flagged.
module ov7670_fb_writer
  import fb_pkg::*;
#(
  parameter int H_PIX   = QVGA_W,
  parameter int V_LINES = QVGA_H
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           cam_data,
  input  logic                 cap_en,
  output logic                 we,
  output logic [FB_ADDR_W-1:0] wAddr,
  output logic [15:0]          wData,
  output logic                 frame_done,
  output logic                 line_ovf
);

  // Counters run one past the last writable index, so saturation itself
  // marks "beyond the window".
  localparam int PIX_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [PIX_W-1:0]  H_MAX = PIX_W'(H_PIX);
  localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);

  fb_state_t            state;
  logic [PIX_W-1:0]     pix_cnt;
  logic [LINE_W-1:0]    line_cnt;
  logic                 href_d;
  logic                 pair_en;
  logic                 pix_done;
  logic [7:0]           hi_byte;
  logic                 in_range;
  logic [FB_ADDR_W-1:0] pix_addr;

  // Bytes count only inside a frame. A vsync rise aborts the line at once.
  assign pair_en = ((state == ACTIVE) || (state == SKIP)) && !vsync;

  rgb565_byte_pair u_byte_pair (
    .clk      (clk),
    .reset    (reset),
    .en       (pair_en),
    .href     (href),
    .cam_data (cam_data),
    .pix_done (pix_done),
    .hi_byte  (hi_byte)
  );

  assign in_range = (pix_cnt < H_MAX) && (line_cnt < V_MAX);
  assign pix_addr = FB_ADDR_W'(line_cnt) * FB_ADDR_W'(H_PIX) + FB_ADDR_W'(pix_cnt);

  // Frame and line sequencing, position counters and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      href_d     <= 1'b0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      line_ovf   <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      href_d     <= href;
      case (state)
        SYNC: begin
          if (vsync) state <= VBLANK;
        end
        VBLANK: begin
          pix_cnt  <= '0;
          line_cnt <= '0;
          if (!vsync) state <= cap_en ? ACTIVE : SKIP;
        end
        ACTIVE, SKIP: begin
          if (vsync) begin
            state      <= VBLANK;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_done <= (state == ACTIVE);
          end else if (pix_done) begin
            if (pix_cnt != H_MAX) pix_cnt <= pix_cnt + PIX_W'(1);
            if (state == ACTIVE) begin
              if (in_range) begin
                we    <= 1'b1;
                wAddr <= pix_addr;
                wData <= {hi_byte, cam_data};
              end else begin
                line_ovf <= 1'b1;
              end
            end
          end else if (href_d && !href) begin
            pix_cnt <= '0;
            if ((pix_cnt != '0) && (line_cnt != V_MAX)) line_cnt <= line_cnt + LINE_W'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Randomized bench for ov7670_fb_writer. Two instances share the stimulus:
// one at full QVGA size and one at 8x4, so that frame-level clipping fits a
// short run. A line/frame-level model predicts every write.
module tb_ov7670_fb_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        cap_en = 1'b0;

  logic        we0, we1;
  logic [16:0] wAddr0, wAddr1;
  logic [15:0] wData0, wData1;
  logic        fd0, fd1;
  logic        ovf0, ovf1;

  always #5 clk = ~clk;

  ov7670_fb_writer #(.H_PIX(320), .V_LINES(240)) dut_full (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
    .cap_en(cap_en), .we(we0), .wAddr(wAddr0), .wData(wData0),
    .frame_done(fd0), .line_ovf(ovf0)
  );

  ov7670_fb_writer #(.H_PIX(8), .V_LINES(4)) dut_small (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
    .cap_en(cap_en), .we(we1), .wAddr(wAddr1), .wData(wData1),
    .frame_done(fd1), .line_ovf(ovf1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-instance capture flag, line index and expected writes.
  typedef struct { int addr; int data; } wr_t;
  wr_t wq0[$];
  wr_t wq1[$];
  int  hp[2] = '{320, 8};
  int  vl[2] = '{240, 4};
  bit  cap[2];
  int  line_no[2];
  bit  ovf_exp[2];
  int  done_exp[2];
  int  done_obs[2];
  int  last_addr[2];
  logic [7:0] byte_buf [1024];

  // A line of nbytes yields nbytes/2 pixels, of which at most max_pix are
  // modelled. Pixel k of line l lands at l*H+k if inside the window.
  task automatic model_line(input int nbytes, input int max_pix, input bit closes);
    int npix;
    npix = nbytes / 2;
    if (npix > max_pix) npix = max_pix;
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        for (int k = 0; k < npix; k++) begin
          if (k < hp[i] && line_no[i] < vl[i]) begin
            wr_t w;
            w.addr = line_no[i] * hp[i] + k;
            w.data = {16'h0, byte_buf[2*k], byte_buf[2*k+1]};
            if (i == 0) wq0.push_back(w); else wq1.push_back(w);
          end else begin
            ovf_exp[i] = 1'b1;
          end
        end
      end
      if (closes && (nbytes / 2) > 0) line_no[i]++;
    end
  endtask

  task automatic gen_bytes(input int n);
    for (int j = 0; j < n; j++) byte_buf[j] = 8'($urandom);
  endtask

  task automatic drive_bytes(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      href = 1'b1;
      cam_data = byte_buf[j];
    end
  endtask

  task automatic end_line();
    @(negedge clk);
    href = 1'b0;
    cam_data = 8'($urandom);
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  task automatic line(input int n);
    gen_bytes(n);
    model_line(n, 1 << 30, 1'b1);
    drive_bytes(n);
    end_line();
  endtask

  // Vertical blank: closes the current frame and arms the next one with ce.
  task automatic vsync_pulse(input bit ce);
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) done_exp[i]++;
      cap[i] = 1'b0;
    end
    @(negedge clk);
    vsync = 1'b1;
    href = 1'b0;
    repeat (3) @(negedge clk);
    cap_en = ce;
    vsync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cap[i] = ce;
      line_no[i] = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_pending0"}, wq0.size(), 0);
    check({tag, "_pending1"}, wq1.size(), 0);
    check({tag, "_done0"}, done_obs[0], done_exp[0]);
    check({tag, "_done1"}, done_obs[1], done_exp[1]);
    check({tag, "_ovf0"}, ovf0, ovf_exp[0]);
    check({tag, "_ovf1"}, ovf1, ovf_exp[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we0"}, we0, 0);
    check({tag, "_we1"}, we1, 0);
    check({tag, "_addr0"}, wAddr0, 0);
    check({tag, "_data0"}, wData0, 0);
    check({tag, "_fd0"}, fd0, 0);
    check({tag, "_ovf0"}, ovf0, 0);
    check({tag, "_addr1"}, wAddr1, 0);
    check({tag, "_ovf1"}, ovf1, 0);
  endtask

  // Write monitors: every strobe must match the next predicted write.
  always @(negedge clk) begin : mon0
    wr_t e;
    if (!reset) begin
      if (we0) begin
        check("wr_expected0", 32'(wq0.size() != 0), 1);
        if (wq0.size() != 0) begin
          e = wq0.pop_front();
          check("waddr0", wAddr0, e.addr);
          check("wdata0", wData0, e.data);
        end
        check("addr_bound0", 32'(int'(wAddr0) < 320 * 240), 1);
        last_addr[0] = int'(wAddr0);
      end
      if (fd0) done_obs[0]++;
    end
  end

  always @(negedge clk) begin : mon1
    wr_t e;
    if (!reset) begin
      if (we1) begin
        check("wr_expected1", 32'(wq1.size() != 0), 1);
        if (wq1.size() != 0) begin
          e = wq1.pop_front();
          check("waddr1", wAddr1, e.addr);
          check("wdata1", wData1, e.data);
        end
        check("addr_bound1", 32'(int'(wAddr1) < 8 * 4), 1);
        last_addr[1] = int'(wAddr1);
      end
      if (fd1) done_obs[1]++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // href before the first vsync must be ignored.
    line(12);
    checkpoint("presync");

    // Frame A: exactly fills the small buffer (4 lines x 8 pixels).
    vsync_pulse(1'b1);
    for (int l = 0; l < 4; l++) line(16);
    vsync_pulse(1'b1);
    checkpoint("frameA");
    check("frameA_last1", last_addr[1], 31);

    // Frame B: full-width line, oversized line, odd-length lines, vsync abort.
    line(640);
    checkpoint("B_line0");
    check("B_line0_last0", last_addr[0], 319);
    cap_en = 1'($urandom);
    line(642);
    checkpoint("B_line1");
    check("B_line1_last0", last_addr[0], 639);
    cap_en = 1'($urandom);
    line(5);
    line(10);
    line(1);
    line(4);
    checkpoint("B_short");
    check("B_short_last0", last_addr[0], 4 * 320 + 1);
    gen_bytes(8);
    model_line(7, 1 << 30, 1'b0);
    drive_bytes(7);
    @(negedge clk);
    vsync = 1'b1;
    href = 1'b1;
    cam_data = byte_buf[7];
    vsync_pulse(1'b0);
    checkpoint("B_abort");

    // Frame C: skipped; cap_en rising mid-frame must not start capture.
    line($urandom_range(16, 2));
    cap_en = 1'b1;
    line($urandom_range(16, 2));
    line($urandom_range(16, 2));
    vsync_pulse(1'b1);
    checkpoint("frameC");

    // Frame D: random line lengths, including empty and single-byte lines.
    for (int l = 0; l < 8; l++) begin
      line($urandom_range(40, 0));
      cap_en = 1'($urandom);
    end
    vsync_pulse(1'b1);
    checkpoint("frameD");

    // Frame E: reset lands in the middle of line 100.
    for (int l = 0; l < 100; l++) line($urandom_range(12, 2));
    gen_bytes(6);
    model_line(6, 2, 1'b0);
    drive_bytes(6);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset_pending0", wq0.size(), 0);
    check("midreset_pending1", wq1.size(), 0);
    for (int i = 0; i < 2; i++) begin
      cap[i] = 1'b0;
      line_no[i] = 0;
      ovf_exp[i] = 1'b0;
    end
    wq0.delete();
    wq1.delete();
    repeat (2) @(negedge clk);
    cam_data = 8'($urandom);
    reset = 1'b0;
    // Rest of the interrupted line and two more lines: no capture yet.
    n = $urandom_range(9, 3);
    gen_bytes(n);
    drive_bytes(n);
    end_line();
    line(16);
    line(20);
    checkpoint("postreset");

    // Fresh vsync high then low: capture restarts at address 0.
    vsync_pulse(1'b1);
    line(16);
    repeat (2) @(negedge clk);
    check("resume_last0", last_addr[0], 7);
    check("resume_last1", last_addr[1], 7);
    line(16);
    vsync_pulse(1'b0);
    checkpoint("resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_fb_writer.md
OV7670_FB_WRITER -- requirements
Module: ov7670_fb_writer

Interface
REQ-001 Parameter H_PIX, default 320, meaning active pixels per line written to the frame buffer.
REQ-002 Parameter V_LINES, default 240, meaning active lines per frame written to the frame buffer.
REQ-003 clk  input  1  single clock, camera pixel clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vsync  input  1  camera frame sync; high = vertical blanking.
REQ-006 href  input  1  camera line valid; high = data byte valid this cycle.
REQ-007 cam_data  input  8  camera byte; RGB565 high byte first, then low byte.
REQ-008 cap_en  input  1  capture enable; sampled only at frame start.
REQ-009 we  output  1  frame buffer write strobe, one cycle per pixel.
REQ-010 wAddr  output  17  frame buffer write address.
REQ-011 wData  output  16  RGB565 pixel, {high byte, low byte}.
REQ-012 frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-013 line_ovf  output  1  sticky flag: a line carried more than H_PIX pixels or a frame more than V_LINES lines.

Function
REQ-014 The FSM SHALL have states SYNC, VBLANK, ACTIVE, SKIP.
REQ-015 SYNC (after reset): move to VBLANK on the first cycle with vsync=1; ignore href until then, so a partial frame is never written.
REQ-016 VBLANK: on vsync=0, go to ACTIVE if cap_en=1, else SKIP; clear pixel counter, line counter and byte phase.
REQ-017 ACTIVE or SKIP: on vsync=1, go to VBLANK; frame_done SHALL pulse for one cycle only when leaving ACTIVE.
REQ-018 Byte phase SHALL toggle on each cycle with href=1; phase 0 latches cam_data as high byte; phase 1 completes a pixel.
REQ-019 In ACTIVE, a completed pixel with pixel counter < H_PIX and line counter < V_LINES SHALL produce, on the next cycle, we=1, wData={high byte, cam_data}, wAddr=line*H_PIX+pixel.
REQ-020 The pixel counter SHALL increment on every completed pixel and saturate at H_PIX; pixels at or beyond H_PIX SHALL not be written and SHALL set line_ovf.
REQ-021 On an href falling edge (href 1 -> 0), the line counter SHALL increment if at least one pixel completed in that line; pixel counter and byte phase SHALL clear.
REQ-022 A dangling high byte (odd byte count) at href fall or vsync rise SHALL be discarded without a write.
REQ-023 Lines with line counter >= V_LINES SHALL not be written and SHALL set line_ovf; the line counter saturates at V_LINES.
REQ-024 vsync rising mid-line SHALL abort the line: no further writes, counters cleared on VBLANK entry.
REQ-025 In SKIP, no writes occur and frame_done stays 0.
REQ-026 wAddr SHALL never exceed H_PIX*V_LINES-1 while we=1.
REQ-027 cap_en changes during ACTIVE or SKIP SHALL have no effect until the next VBLANK exit.
REQ-028 line_ovf SHALL clear only on reset.

Reset
REQ-029 On reset: state=SYNC, we=0, wAddr=0, wData=0, frame_done=0, line_ovf=0, counters=0, byte phase=0, high-byte register=0.
REQ-030 Reset asserted mid-frame SHALL stop writes immediately (we=0 asynchronously) and require a fresh vsync high before capture resumes.

Structure
REQ-031 A shared package fb_pkg SHALL hold FB_ADDR_W=17, QVGA_W=320, QVGA_H=240, FB_DEPTH=76800 and the state enum type.
REQ-032 One sub-module, rgb565_byte_pair, SHALL own the byte phase, high-byte latch and pixel-complete pulse; counters and FSM stay in the top.

Verification
REQ-033 Reset, vsync 1->0 with cap_en=1, one line of 640 bytes -> 320 writes, wAddr 0..319, first wData = {byte0,byte1}, frame_done=0.
REQ-034 Full frame of 240 lines of 640 bytes, then vsync=1 -> 76800 writes, last wAddr=76799, frame_done one pulse, line_ovf=0.
REQ-035 Line of 642 bytes -> 320 writes, 321st pixel dropped, line_ovf=1; next line starts at wAddr=320.
REQ-036 Line of 5 bytes -> 2 writes, fifth byte discarded; next line's first pixel at line*320+0.
REQ-037 cap_en=0 at vsync fall, full frame -> zero writes, no frame_done; cap_en=1 next frame -> normal capture.
REQ-038 Reset asserted at line 100, released mid-frame -> no writes until vsync high then low, next capture starts at wAddr=0.
